hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core.
- Watches register addresses and control bits in the ID, EX, MEM and WB stages.
- Drives stall, flush and forwarding selects for IF2ID, ID2EX, EX2MEM and the EX operand muxes.
- Contains a sequencer that freezes the front of the pipe while the multi-cycle multiply/divide unit runs.

Parameters:
- MD_LATENCY, 32: number of cycles the mul/div unit stays busy after start; legal range 2..255.
- CNT_W, 8: width of the busy counter; must satisfy 2^CNT_W > MD_LATENCY.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- rs_id  in  5  rs field of the instruction in ID.
- rt_id  in  5  rt field of the instruction in ID.
- rs_ex  in  5  rs of the instruction in EX.
- rt_ex  in  5  rt of the instruction in EX.
- regaddr_ex  in  5  destination register in EX.
- regwrite_ex  in  1  EX instruction writes the register file.
- memtoreg_ex  in  1  EX instruction is a load.
- regaddr_mem  in  5  destination register in MEM.
- regwrite_mem  in  1  MEM instruction writes the register file.
- regaddr_wb  in  5  destination register in WB.
- regwrite_wb  in  1  WB instruction writes the register file.
- branch_taken_id  in  1  branch resolved taken in ID.
- jump_id  in  1  jump in ID.
- md_start_ex  in  1  mult/div instruction issuing in EX.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold IF2ID.
- stall_ex  out  1  hold ID2EX.
- flush_id  out  1  clear IF2ID next edge.
- flush_ex  out  1  load a bubble into ID2EX.
- flush_mem  out  1  load a bubble into EX2MEM.
- fwd_a_ex  out  2  forward select for the EX operand A.
- fwd_b_ex  out  2  forward select for the EX operand B.
- md_busy  out  1  mul/div sequencer busy.
- md_done  out  1  one-cycle pulse when mul/div completes.

Behaviour:
- Register state: FSM state and counter only; all outputs are combinational from state and inputs.
- Reset (rst=1 at posedge): state=IDLE, cnt=0. With all inputs at 0, every output is 0.
- Register $0 is never a hazard: any compare where the address is 0 is false.
- The register file writes in the first half-cycle and reads in the second, so WB needs no hazard detection against ID.
- FSM IDLE:
  - md_start_ex=1 -> next state RUN, cnt<=MD_LATENCY-1.
  - In the md_start_ex cycle itself: stall_if, stall_id and stall_ex=1; flush_mem=1.
- FSM RUN:
  - stall_if, stall_id and stall_ex=1; flush_mem=1; md_busy=1.
  - cnt decrements each cycle; at cnt==0 -> next state DONE.
  - md_start_ex is ignored in RUN.
- FSM DONE (1 cycle): md_done=1, no mul/div stall; next state IDLE. md_start_ex in DONE is ignored.
- Total freeze is MD_LATENCY+1 cycles, counting the start cycle.
- Load-use hazard (state IDLE, md_start_ex=0):
  - Condition: regwrite_ex & memtoreg_ex & regaddr_ex!=0 & (regaddr_ex==rs_id | regaddr_ex==rt_id).
  - Response: stall_if=stall_id=1, flush_ex=1, for exactly one cycle per instance.
- Control flow: branch_taken_id|jump_id -> flush_id=1, but only if stall_id=0 that cycle. A stalled branch flushes on the cycle it is released.
- Priority: mul/div freeze > load-use stall > control flush. During a mul/div freeze, flush_ex=0 and flush_id=0.
- Forwarding encoding: 00 = register file, 10 = MEM aluout, 01 = WB result. MEM has priority over WB.

Optional Feature:
- Macro: HAZARD_FWD_EN.
- Defined:
  - fwd_a_ex=10 if regwrite_mem & regaddr_mem!=0 & regaddr_mem==rs_ex.
  - Otherwise fwd_a_ex=01 if regwrite_wb & regaddr_wb!=0 & regaddr_wb==rs_ex.
  - Otherwise fwd_a_ex=00. fwd_b_ex follows the same rules with rt_ex.
  - Only the load-use hazard stalls.
- Not defined:
  - fwd_a_ex and fwd_b_ex are tied to 00.
  - Any ID source matching a nonzero regaddr_ex (regwrite_ex) or regaddr_mem (regwrite_mem) causes a RAW stall: stall_if=stall_id=flush_ex=1, repeating each cycle until the producer reaches WB.

Test Plan:
- Reset check: rst=1 for 2 cycles with random inputs, then all inputs 0 -> all outputs 0, md_busy=0.
- Load-use: regwrite_ex=1, memtoreg_ex=1, regaddr_ex=8, rs_id=8 -> stall_if=stall_id=flush_ex=1 for 1 cycle. Repeat with regaddr_ex=0 -> no stall.
- Mul/div, MD_LATENCY=4: pulse md_start_ex -> stalls high for 5 cycles, md_busy high for 4, then md_done=1 for 1 cycle. A second md_start_ex during RUN -> no extension.
- Branch plus load-use in the same cycle: flush_id=0 while stalled, then flush_id=1 on the following cycle.
- HAZARD_FWD_EN defined: regaddr_mem=5, regaddr_wb=5, both regwrite, rs_ex=5 -> fwd_a_ex=10. Clear regwrite_mem -> fwd_a_ex=01.
- HAZARD_FWD_EN undefined: regwrite_ex=1, regaddr_ex=3, rt_id=3 -> stall 1 cycle. Then regaddr_mem=3 -> stall again. Then regaddr_wb=3 only -> no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: stall/flush/forward selects plus mul/div freeze sequencer.
// Optional macro HAZARD_FWD_EN enables EX operand forwarding (otherwise RAW hazards stall until the producer reaches WB).
module hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic [4:0] rs_ex,
  input  logic [4:0] rt_ex,
  input  logic [4:0] regaddr_ex,
  input  logic       regwrite_ex,
  input  logic       memtoreg_ex,
  input  logic [4:0] regaddr_mem,
  input  logic       regwrite_mem,
  input  logic [4:0] regaddr_wb,
  input  logic       regwrite_wb,
  input  logic       branch_taken_id,
  input  logic       jump_id,
  input  logic       md_start_ex,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       flush_mem,
  output logic [1:0] fwd_a_ex,
  output logic [1:0] fwd_b_ex,
  output logic       md_busy,
  output logic       md_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               md_freeze;
  logic               load_use;
  logic               raw_stall;

  // Register $0 is hardwired to zero, so it never creates a dependency.
  function automatic logic hit(input logic [4:0] dst, input logic we, input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    md_freeze = 1'b0;
    md_busy   = 1'b0;
    md_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_start_ex) begin
          state_d   = RUN;
          cnt_d     = CNT_W'(MD_LATENCY - 1);
          md_freeze = 1'b1;
        end
      end
      RUN: begin
        md_freeze = 1'b1;
        md_busy   = 1'b1;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        md_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_use = memtoreg_ex &&
                    (hit(regaddr_ex, regwrite_ex, rs_id) || hit(regaddr_ex, regwrite_ex, rt_id));

`ifdef HAZARD_FWD_EN
  assign raw_stall = load_use;

  // MEM result is newer than WB, so it wins when both match.
  always_comb begin
    fwd_a_ex = 2'b00;
    fwd_b_ex = 2'b00;
    if (hit(regaddr_mem, regwrite_mem, rs_ex))     fwd_a_ex = 2'b10;
    else if (hit(regaddr_wb, regwrite_wb, rs_ex))  fwd_a_ex = 2'b01;
    if (hit(regaddr_mem, regwrite_mem, rt_ex))     fwd_b_ex = 2'b10;
    else if (hit(regaddr_wb, regwrite_wb, rt_ex))  fwd_b_ex = 2'b01;
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{rs_ex, rt_ex, regaddr_wb, regwrite_wb};

  assign raw_stall = load_use ||
                     hit(regaddr_ex,  regwrite_ex,  rs_id) || hit(regaddr_ex,  regwrite_ex,  rt_id) ||
                     hit(regaddr_mem, regwrite_mem, rs_id) || hit(regaddr_mem, regwrite_mem, rt_id);

  always_comb begin
    fwd_a_ex = 2'b00;
    fwd_b_ex = 2'b00;
  end
`endif

  // Freeze beats data stall beats control flush; a held branch flushes once released.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    if (md_freeze) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      flush_mem = 1'b1;
    end else if (raw_stall) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end else if (branch_taken_id || jump_id) begin
      flush_id = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table for the combinational decode plus sequences for reset, mul/div freeze and stalled branch.
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_id, rt_id, rs_ex, rt_ex, regaddr_ex, regaddr_mem, regaddr_wb;
  logic       regwrite_ex, memtoreg_ex, regwrite_mem, regwrite_wb;
  logic       branch_taken_id, jump_id, md_start_ex;
  logic       stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem;
  logic [1:0] fwd_a_ex, fwd_b_ex;
  logic       md_busy, md_done;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.MD_LATENCY(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
    .regaddr_ex(regaddr_ex), .regwrite_ex(regwrite_ex), .memtoreg_ex(memtoreg_ex),
    .regaddr_mem(regaddr_mem), .regwrite_mem(regwrite_mem),
    .regaddr_wb(regaddr_wb), .regwrite_wb(regwrite_wb),
    .branch_taken_id(branch_taken_id), .jump_id(jump_id), .md_start_ex(md_start_ex),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
    .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex), .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  // Output word: {stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem, fwd_a[1:0], fwd_b[1:0], md_busy, md_done}
  localparam logic [11:0] O_NONE   = 12'h000;
  localparam logic [11:0] O_STALL  = 12'hC80;
  localparam logic [11:0] O_FLUSH  = 12'h100;
  localparam logic [11:0] O_START  = 12'hE40;
  localparam logic [11:0] O_RUN    = 12'hE42;
  localparam logic [11:0] O_DONE   = 12'h001;

  typedef struct packed {
    logic [4:0]  rs_id, rt_id, rs_ex, rt_ex;
    logic [4:0]  ra_ex;  logic rw_ex; logic mtr_ex;
    logic [4:0]  ra_mem; logic rw_mem;
    logic [4:0]  ra_wb;  logic rw_wb;
    logic        br, jmp;
    logic [11:0] exp_nofwd;
    logic [11:0] exp_fwd;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [11:0] outs();
    return {stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_mem,
            fwd_a_ex, fwd_b_ex, md_busy, md_done};
  endfunction

  task automatic check(input string name, input logic [11:0] exp);
    logic [11:0] act;
    act = outs();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs=%03h expected=%03h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    rs_id = 0; rt_id = 0; rs_ex = 0; rt_ex = 0;
    regaddr_ex = 0; regwrite_ex = 0; memtoreg_ex = 0;
    regaddr_mem = 0; regwrite_mem = 0; regaddr_wb = 0; regwrite_wb = 0;
    branch_taken_id = 0; jump_id = 0; md_start_ex = 0;
  endtask

  task automatic add(input logic [4:0] rsi, rti, rse, rte, rae, input logic rwe, mtr,
                     input logic [4:0] ram, input logic rwm, input logic [4:0] raw, input logic rww,
                     input logic br, jmp, input logic [11:0] e_nofwd, e_fwd);
    vec_t v;
    v.rs_id = rsi; v.rt_id = rti; v.rs_ex = rse; v.rt_ex = rte;
    v.ra_ex = rae; v.rw_ex = rwe; v.mtr_ex = mtr;
    v.ra_mem = ram; v.rw_mem = rwm; v.ra_wb = raw; v.rw_wb = rww;
    v.br = br; v.jmp = jmp; v.exp_nofwd = e_nofwd; v.exp_fwd = e_fwd;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    //   rs_id rt_id rs_ex rt_ex ra_ex rwe mtr ra_mem rwm ra_wb rww br jmp  nofwd    fwd
    add(0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE,  O_NONE);   // idle
    add(8,  0,  0,  0,  8, 1, 1, 0, 0, 0, 0, 0, 0, O_STALL, O_STALL);  // load-use rs
    add(0,  0,  0,  0,  0, 1, 1, 0, 0, 0, 0, 0, 0, O_NONE,  O_NONE);   // load to $0
    add(1,  9,  0,  0,  9, 1, 1, 0, 0, 0, 0, 0, 0, O_STALL, O_STALL);  // load-use rt
    add(8,  0,  0,  0,  8, 0, 1, 0, 0, 0, 0, 0, 0, O_NONE,  O_NONE);   // no regwrite
    add(0,  3,  0,  0,  3, 1, 0, 0, 0, 0, 0, 0, 0, O_STALL, O_NONE);   // ALU RAW from EX
    add(0,  3,  0,  0,  0, 0, 0, 3, 1, 0, 0, 0, 0, O_STALL, O_NONE);   // RAW from MEM
    add(0,  3,  0,  0,  0, 0, 0, 0, 0, 3, 1, 0, 0, O_NONE,  O_NONE);   // WB only
    add(0,  0,  5,  0,  0, 0, 0, 5, 1, 5, 1, 0, 0, O_NONE,  12'h020);  // fwd A MEM over WB
    add(0,  0,  5,  0,  0, 0, 0, 5, 0, 5, 1, 0, 0, O_NONE,  12'h010);  // fwd A WB
    add(0,  0,  7,  6,  0, 0, 0, 6, 1, 7, 1, 0, 0, O_NONE,  12'h018);  // A=WB, B=MEM
    add(0,  0,  0,  0,  0, 0, 0, 0, 1, 0, 1, 0, 0, O_NONE,  O_NONE);   // $0 never forwards
    add(0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 1, 0, O_FLUSH, O_FLUSH);  // branch
    add(0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0, 1, O_FLUSH, O_FLUSH);  // jump
    add(8,  0,  0,  0,  8, 1, 1, 0, 0, 0, 0, 1, 0, O_STALL, O_STALL);  // branch held by load-use
    add(4,  0,  0,  0,  4, 1, 0, 0, 0, 0, 0, 1, 0, O_STALL, O_FLUSH);  // branch vs ALU RAW

    // Reset with random inputs, then quiet inputs must give all-zero outputs.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rs_id = 5'($urandom); rt_id = 5'($urandom); rs_ex = 5'($urandom); rt_ex = 5'($urandom);
      regaddr_ex = 5'($urandom); regwrite_ex = 1'($urandom); memtoreg_ex = 1'($urandom);
      regaddr_mem = 5'($urandom); regwrite_mem = 1'($urandom);
      regaddr_wb = 5'($urandom); regwrite_wb = 1'($urandom);
      branch_taken_id = 1'($urandom); jump_id = 1'($urandom); md_start_ex = 1'($urandom);
      @(posedge clk); #1;
    end
    clear_inputs();
    @(negedge clk);
    check("reset_outputs", O_NONE);
    step();
    rst = 1'b0;

    foreach (vecs[i]) begin
      step();
      rs_id = vecs[i].rs_id; rt_id = vecs[i].rt_id; rs_ex = vecs[i].rs_ex; rt_ex = vecs[i].rt_ex;
      regaddr_ex = vecs[i].ra_ex; regwrite_ex = vecs[i].rw_ex; memtoreg_ex = vecs[i].mtr_ex;
      regaddr_mem = vecs[i].ra_mem; regwrite_mem = vecs[i].rw_mem;
      regaddr_wb = vecs[i].ra_wb; regwrite_wb = vecs[i].rw_wb;
      branch_taken_id = vecs[i].br; jump_id = vecs[i].jmp; md_start_ex = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d", i), FWD ? vecs[i].exp_fwd : vecs[i].exp_nofwd);
    end

    // Mul/div freeze, latency 4: start + 4 RUN cycles, then one DONE cycle.
    step(); clear_inputs();
    md_start_ex = 1'b1;
    @(negedge clk); check("md_start", O_START);
    step(); md_start_ex = 1'b0;
    @(negedge clk); check("md_run1", O_RUN);
    step(); md_start_ex = 1'b1;                       // restart attempt during RUN
    @(negedge clk); check("md_run2_restart", O_RUN);
    step(); md_start_ex = 1'b0; branch_taken_id = 1'b1;
    regaddr_ex = 8; regwrite_ex = 1'b1; memtoreg_ex = 1'b1; rs_id = 8;
    @(negedge clk); check("md_run3_masks_hazards", O_RUN);
    step(); clear_inputs();
    @(negedge clk); check("md_run4", O_RUN);
    step(); md_start_ex = 1'b1;                       // start in DONE is ignored
    @(negedge clk); check("md_done", O_DONE);
    step(); md_start_ex = 1'b0;
    @(negedge clk); check("md_back_idle", O_NONE);

    // Branch held by a load-use stall flushes on the release cycle.
    step(); clear_inputs();
    branch_taken_id = 1'b1; regaddr_ex = 8; regwrite_ex = 1'b1; memtoreg_ex = 1'b1; rs_id = 8;
    @(negedge clk); check("branch_stalled", O_STALL);
    step(); regaddr_ex = 0; regwrite_ex = 1'b0; memtoreg_ex = 1'b0;
    @(negedge clk); check("branch_released", O_FLUSH);

    // RAW sequence following the producer from EX through MEM to WB.
    step(); clear_inputs();
    regaddr_ex = 3; regwrite_ex = 1'b1; rt_id = 3;
    @(negedge clk); check("raw_ex", FWD ? O_NONE : O_STALL);
    step(); regaddr_ex = 0; regwrite_ex = 1'b0; regaddr_mem = 3; regwrite_mem = 1'b1;
    @(negedge clk); check("raw_mem", FWD ? O_NONE : O_STALL);
    step(); regaddr_mem = 0; regwrite_mem = 1'b0; regaddr_wb = 3; regwrite_wb = 1'b1;
    @(negedge clk); check("raw_wb", O_NONE);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
